// File: rtl/uart_tx_arbiter_if.sv
// rtl/uart_tx_arbiter_if.sv - producer handshake and uart-side bundle for uart_tx_arbiter
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ = 2
);
    logic [NUM_REQ-1:0]   req_valid;
    logic [NUM_REQ*8-1:0] req_data;
    logic [NUM_REQ-1:0]   req_last;
    logic [NUM_REQ-1:0]   req_ready;
    logic [2:0]           grant_id;
    logic                 uart_transmit;
    logic [7:0]           uart_tx_byte;
    logic                 uart_is_transmitting;
    logic                 busy;
    logic                 timeout_err;

    modport master (
        output req_valid, req_data, req_last, uart_is_transmitting,
        input  req_ready, grant_id, uart_transmit, uart_tx_byte, busy, timeout_err
    );

    modport slave (
        input  req_valid, req_data, req_last, uart_is_transmitting,
        output req_ready, grant_id, uart_transmit, uart_tx_byte, busy, timeout_err
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin byte arbiter feeding one uart transmit channel
// Optional message locking via `define ARB_LOCK_EN.
module uart_tx_arbiter #(
    parameter int NUM_REQ        = 2,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    uart_tx_arbiter_if.slave  arb
);
    typedef enum logic [1:0] {IDLE, START, WAIT_RISE, WAIT_FALL} state_t;

    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      state, state_next;
    logic [2:0]  last_grant;
    logic [7:0]  tx_byte_r;
    logic [15:0] tmo_cnt;
    logic [7:0]  valid8, cand8, ready8, last8;
    logic [63:0] data64;
    logic [2:0]  win, idx3;
    logic        win_found;
    logic        accept;
    logic        timeout;
    int          idx;

`ifdef ARB_LOCK_EN
    logic lock_r;
`endif

    assign valid8 = 8'(arb.req_valid);
    assign last8  = 8'(arb.req_last);
    assign data64 = 64'(arb.req_data);

    // While a message is locked only its owner (last_grant) may compete.
    always_comb begin
        cand8 = valid8;
`ifdef ARB_LOCK_EN
        if (lock_r)
            cand8 = valid8 & (8'd1 << last_grant);
`endif
    end

    always_comb begin
        win       = '0;
        win_found = 1'b0;
        idx       = 0;
        idx3      = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = int'(last_grant) + k;
            if (idx >= NUM_REQ)
                idx = idx - NUM_REQ;
            idx3 = 3'(idx);
            if (!win_found && cand8[idx3]) begin
                win       = idx3;
                win_found = 1'b1;
            end
        end
    end

    assign accept = rst_n && (state == IDLE) && !arb.uart_is_transmitting && win_found;

    always_comb begin
        ready8 = '0;
        if (accept)
            ready8[win] = 1'b1;
    end

    always_comb begin
        state_next = state;
        timeout    = 1'b0;
        case (state)
            IDLE:      if (accept) state_next = START;
            START:     state_next = WAIT_RISE;
            WAIT_RISE: begin
                if (arb.uart_is_transmitting) begin
                    state_next = WAIT_FALL;
                end else if (tmo_cnt == TMO_LAST) begin
                    timeout    = 1'b1;
                    state_next = IDLE;
                end
            end
            WAIT_FALL: if (!arb.uart_is_transmitting) state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= 3'(NUM_REQ - 1);
            tx_byte_r  <= '0;
            tmo_cnt    <= '0;
        end else begin
            if (accept) begin
                last_grant <= win;
                tx_byte_r  <= data64[{win, 3'b000} +: 8];
            end
            if (state == START)
                tmo_cnt <= '0;
            else if (state == WAIT_RISE && !arb.uart_is_transmitting)
                tmo_cnt <= tmo_cnt + 16'd1;
        end
    end

`ifdef ARB_LOCK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            lock_r <= 1'b0;
        else if (accept)
            lock_r <= !last8[win];
        else if (timeout)
            lock_r <= 1'b0;
    end
`endif

    assign arb.req_ready     = ready8[NUM_REQ-1:0];
    assign arb.grant_id      = last_grant;
    assign arb.uart_transmit = (state == START);
    assign arb.uart_tx_byte  = tx_byte_r;
    assign arb.busy          = (state != IDLE);
    assign arb.timeout_err   = timeout;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - self-checking bench for uart_tx_arbiter with a uart BFM
module tb_uart_tx_arbiter;
    localparam int NR  = 4;
    localparam int TMO = 16;
`ifdef ARB_LOCK_EN
    localparam bit LOCK = 1'b1;
`else
    localparam bit LOCK = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    uart_tx_arbiter_if #(.NUM_REQ(NR)) bus ();

    uart_tx_arbiter #(.NUM_REQ(NR), .TIMEOUT_CYCLES(TMO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .arb   (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // UART model: is_transmitting rises one cycle after transmit, stays high 100 cycles.
    int   bfm_cnt = 0;
    logic bfm_en  = 1'b1;
    logic force_hi = 1'b0;
    always @(posedge clk) begin
        if (bus.uart_transmit && bfm_en)
            bfm_cnt <= 100;
        else if (bfm_cnt > 0)
            bfm_cnt <= bfm_cnt - 1;
    end
    assign bus.uart_is_transmitting = (bfm_cnt > 0) || force_hi;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0]    obs_b[$];
    logic [2:0]    obs_i[$];
    logic [7:0]    exp_b[$];
    logic [2:0]    exp_i[$];
    int            tx_cyc  = -1;
    int            tmo_cyc = -1;
    logic [NR-1:0] rdy_acc;

    always @(negedge clk) begin
        rdy_acc = rst_n ? (bus.req_ready & bus.req_valid) : '0;
        if (rst_n) begin
            if (bus.uart_transmit) begin
                obs_b.push_back(bus.uart_tx_byte);
                obs_i.push_back(bus.grant_id);
                tx_cyc = cyc;
            end
            if (bus.timeout_err && tmo_cyc < 0)
                tmo_cyc = cyc;
            if (bus.req_ready != '0)
                check("ready_onehot_idle", {31'b0, $onehot(bus.req_ready) && !bus.busy}, 32'd1);
        end
    end

    // Producer byte lists: pd/pl per requester, pn entries, pr consumed.
    logic [7:0] pd[NR][32];
    logic       pl[NR][32];
    int         pn[NR];
    int         pr[NR];

    task automatic drive();
        logic [NR-1:0]   v;
        logic [NR-1:0]   l;
        logic [NR*8-1:0] d;
        v = '0; l = '0; d = '0;
        for (int i = 0; i < NR; i++) begin
            if (pr[i] < pn[i]) begin
                v[i]       = 1'b1;
                l[i]       = pl[i][pr[i]];
                d[i*8 +: 8] = pd[i][pr[i]];
            end
        end
        bus.req_valid = v;
        bus.req_last  = l;
        bus.req_data  = d;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        for (int i = 0; i < NR; i++)
            if (rdy_acc[i]) pr[i]++;
        drive();
    endtask

    task automatic clear_lists();
        for (int i = 0; i < NR; i++) begin
            pn[i] = 0;
            pr[i] = 0;
        end
        obs_b.delete(); obs_i.delete();
        tx_cyc = -1; tmo_cyc = -1;
    endtask

    task automatic do_reset();
        int n;
        n = 0;
        while (bfm_cnt > 0 && n < 300) begin @(posedge clk); n++; end
        #1;
        rst_n = 1'b0;
        clear_lists();
        drive();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Reference: serve pending lists fairly in rotation from 'start'; with locking,
    // a requester keeps the channel until it sends a byte marked last.
    task automatic build_expected(input int start);
        int rd[NR];
        int ptr, total, c;
        bit locked, found;
        exp_b.delete(); exp_i.delete();
        total = 0;
        for (int i = 0; i < NR; i++) begin rd[i] = 0; total += pn[i]; end
        ptr = start; locked = 1'b0;
        for (int n = 0; n < total; n++) begin
            c = ptr;
            if (!locked) begin
                found = 1'b0;
                for (int k = 1; k <= NR; k++)
                    if (!found && rd[(ptr + k) % NR] < pn[(ptr + k) % NR]) begin
                        c = (ptr + k) % NR;
                        found = 1'b1;
                    end
            end
            exp_b.push_back(pd[c][rd[c]]);
            exp_i.push_back(3'(c));
            locked = LOCK && !pl[c][rd[c]];
            rd[c]++;
            ptr = c;
        end
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n;
        n = 0;
        while ((bus.busy || bus.uart_is_transmitting) && n < budget) begin tick(); n++; end
        check({tag, "_idle_reached"}, {31'b0, n < budget}, 32'd1);
    endtask

    task automatic run_compare(input string tag, input int budget);
        int n, m;
        n = 0;
        while (obs_b.size() < exp_b.size() && n < budget) begin tick(); n++; end
        check({tag, "_count"}, 32'(obs_b.size()), 32'(exp_b.size()));
        m = (obs_b.size() < exp_b.size()) ? obs_b.size() : exp_b.size();
        for (int i = 0; i < m; i++) begin
            check($sformatf("%s_byte%0d", tag, i), {24'b0, obs_b[i]}, {24'b0, exp_b[i]});
            check($sformatf("%s_id%0d", tag, i), {29'b0, obs_i[i]}, {29'b0, exp_i[i]});
        end
        wait_idle(tag, 400);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"},    32'(bus.req_ready), 32'd0);
        check({tag, "_transmit"}, {31'b0, bus.uart_transmit}, 32'd0);
        check({tag, "_tx_byte"},  {24'b0, bus.uart_tx_byte}, 32'd0);
        check({tag, "_grant"},    {29'b0, bus.grant_id}, 32'(NR - 1));
        check({tag, "_busy"},     {31'b0, bus.busy}, 32'd0);
        check({tag, "_timeout"},  {31'b0, bus.timeout_err}, 32'd0);
    endtask

    initial begin
        int n;
        logic [NR-1:0] seen;

        rst_n = 1'b0;
        clear_lists();
        drive();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Single byte from requester 0.
        do_reset();
        pd[0][0] = 8'h41; pl[0][0] = 1'b1; pn[0] = 1;
        drive();
        @(negedge clk); #1;
        check("single_ready", 32'(bus.req_ready), 32'h1);
        tick();
        @(negedge clk); #1;
        check("single_transmit", {31'b0, bus.uart_transmit}, 32'd1);
        check("single_tx_byte", {24'b0, bus.uart_tx_byte}, 32'h41);
        check("single_grant", {29'b0, bus.grant_id}, 32'd0);
        check("single_busy", {31'b0, bus.busy}, 32'd1);
        wait_idle("single", 300);
        check("single_busy_low", {31'b0, bus.busy}, 32'd0);
        check("single_byte_hold", {24'b0, bus.uart_tx_byte}, 32'h41);
        check("single_count", 32'(obs_b.size()), 32'd1);

        // Two requesters continuously valid.
        do_reset();
        for (int j = 0; j < 3; j++) begin
            pd[0][j] = 8'hA0 + 8'(j); pl[0][j] = 1'b1;
            pd[1][j] = 8'hB0 + 8'(j); pl[1][j] = 1'b1;
        end
        pn[0] = 3; pn[1] = 3;
        build_expected(NR - 1);
        drive();
        run_compare("rr2", 2000);

        // No UART response: timeout then next requester.
        do_reset();
        bfm_en = 1'b0;
        pd[0][0] = 8'h55; pl[0][0] = 1'b1; pn[0] = 1;
        pd[1][0] = 8'h66; pl[1][0] = 1'b1; pn[1] = 1;
        drive();
        n = 0;
        while (tmo_cyc < 0 && n < 100) begin tick(); n++; end
        check("timeout_seen", {31'b0, tmo_cyc >= 0}, 32'd1);
        check("timeout_delay", 32'(tmo_cyc - tx_cyc), 32'd16);
        n = 0;
        while (obs_b.size() < 2 && n < 100) begin tick(); n++; end
        check("timeout_next_count", 32'(obs_b.size()), 32'd2);
        if (obs_b.size() >= 2) begin
            check("timeout_next_byte", {24'b0, obs_b[1]}, 32'h66);
            check("timeout_next_id", {29'b0, obs_i[1]}, 32'd1);
        end
        repeat (30) tick();
        bfm_en = 1'b1;

        // is_transmitting held high in IDLE blocks acceptance.
        do_reset();
        force_hi = 1'b1;
        pd[1][0] = 8'h77; pl[1][0] = 1'b1; pn[1] = 1;
        drive();
        seen = '0;
        for (int j = 0; j < 8; j++) begin
            @(negedge clk); #1;
            seen |= bus.req_ready;
            tick();
        end
        check("blocked_ready", 32'(seen), 32'd0);
        force_hi = 1'b0;
        @(negedge clk); #1;
        check("unblocked_ready", 32'(bus.req_ready), 32'h2);
        tick();
        wait_idle("unblocked", 300);

        // Message of three bytes from requester 0 against requester 1.
        do_reset();
        pd[0][0] = 8'h10; pl[0][0] = 1'b0;
        pd[0][1] = 8'h11; pl[0][1] = 1'b0;
        pd[0][2] = 8'h12; pl[0][2] = 1'b1; pn[0] = 3;
        pd[1][0] = 8'h20; pl[1][0] = 1'b1; pn[1] = 1;
        build_expected(NR - 1);
        drive();
        run_compare("lock", 2000);

        // Randomized lists on all requesters.
        for (int r = 0; r < 3; r++) begin
            do_reset();
            for (int i = 0; i < NR; i++) begin
                pn[i] = $urandom_range(0, 4);
                for (int j = 0; j < pn[i]; j++) begin
                    pd[i][j] = 8'($urandom);
                    pl[i][j] = (j == pn[i] - 1) ? 1'b1 : 1'($urandom_range(0, 1));
                end
            end
            build_expected(NR - 1);
            drive();
            run_compare($sformatf("rand%0d", r), 3000);
        end

        // Reset while the UART frame is in flight.
        do_reset();
        pd[0][0] = 8'h99; pl[0][0] = 1'b1; pn[0] = 1;
        drive();
        n = 0;
        while (!(bus.busy && bus.uart_is_transmitting) && n < 20) begin tick(); n++; end
        repeat (5) tick();
        check("midrst_in_wait_fall", {31'b0, bus.busy && bus.uart_is_transmitting}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        clear_lists();
        pd[0][0] = 8'hC0; pl[0][0] = 1'b1; pn[0] = 1;
        pd[1][0] = 8'hC1; pl[1][0] = 1'b1; pn[1] = 1;
        drive();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        build_expected(NR - 1);
        run_compare("midrst", 1000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
